// File: rtl/filtros_pkg.sv
// Shared definitions for the filter stages: FSM state encoding, FIFO read latency, clog2 helper.
// Rounding of the moving average is selected by the PROMEDIO_REDONDEO_EN macro in promediador_fifo.
package filtros_pkg;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_POP  = 2'd1,
    E_CAPT = 2'd2,
    E_OUT  = 2'd3
  } estado_t;

  // The upstream FIFO presents data_out one cycle after the pop strobe.
  localparam int FIFO_RD_LAT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/promediador_fifo_if.sv
// Bundle between the FIFO buffer, the moving-average stage and its downstream consumer.
// Handshake: avg_data is transferred on a rising clk edge where avg_valid && avg_ready; while avg_valid is high
// and avg_ready is low, avg_data is held stable. fifo_pop is a one-cycle pulse; fifo_data is valid one cycle later.
interface promediador_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_nocfg;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_pop;
  logic                  clear;
  logic [DATA_WIDTH-1:0] avg_data;
  logic                  avg_valid;
  logic                  avg_ready;
  logic                  window_full;

  modport slave (
    input  fifo_push, fifo_full, fifo_nocfg, fifo_data, clear, avg_ready,
    output fifo_pop, avg_data, avg_valid, window_full
  );

  modport master (
    output fifo_push, fifo_full, fifo_nocfg, fifo_data, clear, avg_ready,
    input  fifo_pop, avg_data, avg_valid, window_full
  );
endinterface

// File: rtl/ventana_desplazamiento.sv
// TAPS-deep sample window: shifts a new sample in on shift_en_i, exposes the sample about to fall out
// and how many samples have been captured since reset/clear (saturating at TAPS).
module ventana_desplazamiento
  import filtros_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  TAPS       = 4,
  localparam int FILL_W     = clog2(TAPS) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_en_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic [DATA_WIDTH-1:0] oldest_o,
  output logic [FILL_W-1:0]     fill_o
);

  logic [DATA_WIDTH-1:0] taps_q [TAPS];
  logic [DATA_WIDTH-1:0] taps_d [TAPS];
  logic [FILL_W-1:0]     fill_q, fill_d;

  always_comb begin
    taps_d = taps_q;
    fill_d = fill_q;
    if (clear_i) begin
      for (int i = 0; i < TAPS; i++) taps_d[i] = '0;
      fill_d = '0;
    end else if (shift_en_i) begin
      taps_d[0] = sample_i;
      for (int i = 1; i < TAPS; i++) taps_d[i] = taps_q[i-1];
      if (fill_q != FILL_W'(TAPS)) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
      fill_q <= '0;
    end else begin
      taps_q <= taps_d;
      fill_q <= fill_d;
    end
  end

  // Unfilled slots hold zero, so the outgoing sample is 0 until the window is full.
  assign oldest_o = taps_q[TAPS-1];
  assign fill_o   = fill_q;

endmodule

// File: rtl/promediador_fifo.sv
// Moving-average consumer of the FIFO buffer: tracks FIFO occupancy, pops one sample at a time, keeps a running
// window sum and offers the average on a valid/ready port. Define PROMEDIO_REDONDEO_EN for round-half-up output.
module promediador_fifo
  import filtros_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TAPS       = 4,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  promediador_fifo_if.slave    bus,
  output estado_t              dbg_state_o,
  output logic [CNT_WIDTH-1:0] dbg_occ_o
);

  localparam int LOG2_TAPS = clog2(TAPS);
  localparam int FILL_W    = LOG2_TAPS + 1;
`ifdef PROMEDIO_REDONDEO_EN
  localparam int SUM_W     = DATA_WIDTH + LOG2_TAPS + 1;
`else
  localparam int SUM_W     = DATA_WIDTH + LOG2_TAPS;
`endif
  localparam logic [CNT_WIDTH-1:0] OCC_MAX = '1;

  estado_t               state_q;
  logic                  fifo_pop_q;
  logic                  avg_valid_q;
  logic [DATA_WIDTH-1:0] avg_data_q, avg_d;
  logic [SUM_W-1:0]      sum_q, sum_d, avg_shift;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] oldest;
  logic [FILL_W-1:0]     fill;
  logic                  push_ok;
  logic                  shift_en;
  logic                  full_after;

  ventana_desplazamiento #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (TAPS)
  ) u_ventana (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (shift_en),
    .clear_i    (bus.clear),
    .sample_i   (bus.fifo_data),
    .oldest_o   (oldest),
    .fill_o     (fill)
  );

  assign push_ok  = bus.fifo_push && !bus.fifo_full;
  // A clear during CAPT still consumes the popped sample, but it is flushed together with the window.
  assign shift_en = (state_q == E_CAPT) && !bus.clear;
  assign full_after = (fill >= FILL_W'(TAPS - 1));
  assign sum_d    = sum_q + SUM_W'(bus.fifo_data) - SUM_W'(oldest);

  always_comb begin
    occ_d = occ_q;
    if (push_ok && !fifo_pop_q) begin
      if (occ_q != OCC_MAX) occ_d = occ_q + 1'b1;
    end else if (!push_ok && fifo_pop_q) begin
      if (occ_q != '0) occ_d = occ_q - 1'b1;
    end
  end

  always_comb begin
`ifdef PROMEDIO_REDONDEO_EN
    avg_shift = (sum_d + SUM_W'(TAPS / 2)) >> LOG2_TAPS;
    if (avg_shift > SUM_W'({DATA_WIDTH{1'b1}})) avg_d = '1;
    else                                        avg_d = DATA_WIDTH'(avg_shift);
`else
    avg_shift = sum_d >> LOG2_TAPS;
    avg_d     = DATA_WIDTH'(avg_shift);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= E_IDLE;
      fifo_pop_q  <= 1'b0;
      avg_valid_q <= 1'b0;
      avg_data_q  <= '0;
      sum_q       <= '0;
      occ_q       <= '0;
    end else begin
      occ_q      <= occ_d;
      fifo_pop_q <= 1'b0;
      case (state_q)
        E_IDLE: begin
          if (bus.clear) begin
            sum_q <= '0;
          end else if (occ_q != '0 && !bus.fifo_nocfg) begin
            fifo_pop_q <= 1'b1;
            state_q    <= E_POP;
          end
        end
        E_POP: begin
          if (bus.clear) begin
            sum_q   <= '0;
            state_q <= E_IDLE;
          end else begin
            state_q <= E_CAPT;
          end
        end
        E_CAPT: begin
          if (bus.clear) begin
            sum_q   <= '0;
            state_q <= E_IDLE;
          end else begin
            sum_q <= sum_d;
            if (full_after) begin
              avg_data_q  <= avg_d;
              avg_valid_q <= 1'b1;
              state_q     <= E_OUT;
            end else begin
              state_q <= E_IDLE;
            end
          end
        end
        E_OUT: begin
          if (bus.clear) begin
            sum_q       <= '0;
            avg_valid_q <= 1'b0;
            state_q     <= E_IDLE;
          end else if (bus.avg_ready) begin
            avg_valid_q <= 1'b0;
            state_q     <= E_IDLE;
          end
        end
        default: state_q <= E_IDLE;
      endcase
    end
  end

  assign bus.fifo_pop    = fifo_pop_q;
  assign bus.avg_valid   = avg_valid_q;
  assign bus.avg_data    = avg_data_q;
  assign bus.window_full = (fill == FILL_W'(TAPS));
  assign dbg_state_o     = state_q;
  assign dbg_occ_o       = occ_q;

endmodule

// File: tb/tb_promediador_fifo.sv
// Bench for promediador_fifo: behavioural FIFO plus a window/average model feeding an expected queue,
// a per-cycle occupancy reference, and scenario tasks run in sequence.
module tb_promediador_fifo;
  import filtros_pkg::*;

  localparam int DW     = 8;
  localparam int TAPS   = 4;
  localparam int CW     = 6;
  localparam int OCCMAX = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  estado_t       dbg_state;
  logic [CW-1:0] dbg_occ;

  promediador_fifo_if #(.DATA_WIDTH(DW)) bus ();

  promediador_fifo #(
    .DATA_WIDTH (DW),
    .TAPS       (TAPS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_occ_o   (dbg_occ)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_pops   = 0;
  int            n_out    = 0;
  int            cyc      = 0;
  int            last_pop_cyc = 0;
  int            ref_occ  = 0;
  int            tot;
  logic          prev_pop   = 1'b0;
  logic          prev_valid = 1'b0;
  logic          push_ok;
  logic          pop_now;
  logic [DW-1:0] push_data;
  logic [DW-1:0] last_avg;
  logic [DW-1:0] s, e;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  int            hist   [$];

  function automatic logic [DW-1:0] ref_avg(input int total);
    int r;
`ifdef PROMEDIO_REDONDEO_EN
    r = (total + TAPS / 2) / TAPS;
    if (r > 255) r = 255;
`else
    r = total / TAPS;
`endif
    return DW'(r);
  endfunction

  // ---------------- FIFO model, reference model and scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (reset !== 1'b1) begin
      fifo_q.delete();
      exp_q.delete();
      hist.delete();
      ref_occ    = 0;
      prev_pop   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      n_checks++;
      if (dbg_occ !== CW'(ref_occ)) begin
        n_errors++;
        $display("FAIL occ_count: got %0d expected %0d (cycle %0d)", dbg_occ, ref_occ, cyc);
      end
      if (bus.avg_valid === 1'b1 && prev_valid === 1'b0) begin
        n_checks++;
        if (cyc - last_pop_cyc != 2) begin
          n_errors++;
          $display("FAIL latency: got %0d cycles expected 2", cyc - last_pop_cyc);
        end
      end
      if (bus.avg_valid === 1'b1 && bus.avg_ready === 1'b1) begin
        n_out++;
        last_avg = bus.avg_data;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL avg_unexpected: got %0d expected no output", bus.avg_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.avg_data !== e) begin
            n_errors++;
            $display("FAIL avg_data: got %0d expected %0d", bus.avg_data, e);
          end
        end
      end
      pop_now = (bus.fifo_pop === 1'b1);
      if (pop_now) begin
        n_pops++;
        last_pop_cyc = cyc;
        n_checks++;
        if (prev_pop === 1'b1 || fifo_q.size() == 0) begin
          n_errors++;
          $display("FAIL pop_rule: got prev_pop=%0b fifo_size=%0d expected prev_pop=0 fifo_size>0",
                   prev_pop, fifo_q.size());
        end else begin
          s = fifo_q.pop_front();
          bus.fifo_data = s;
          hist.push_back(int'(s));
          if (hist.size() > TAPS) void'(hist.pop_front());
          if (hist.size() == TAPS) begin
            tot = 0;
            foreach (hist[i]) tot += hist[i];
            exp_q.push_back(ref_avg(tot));
          end
        end
      end
      push_ok = (bus.fifo_push === 1'b1) && (bus.fifo_full !== 1'b1);
      if (push_ok) fifo_q.push_back(push_data);
      if (push_ok && !pop_now)      ref_occ = (ref_occ == OCCMAX) ? OCCMAX : ref_occ + 1;
      else if (!push_ok && pop_now) ref_occ = (ref_occ == 0) ? 0 : ref_occ - 1;
      prev_pop   = bus.fifo_pop;
      prev_valid = bus.avg_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [DW-1:0] v);
    bus.fifo_push = 1'b1;
    push_data     = v;
    tick();
    bus.fifo_push = 1'b0;
  endtask

  task automatic model_clear();
    hist.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (!(fifo_q.size() == 0 && dbg_occ == 0 && dbg_state == E_IDLE && bus.avg_valid == 1'b0)
           && k < budget) begin
      tick();
      k++;
    end
    tick();
    n_checks++;
    if (k >= budget) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d cycles expected < %0d", tag, k, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k;
    k = 0;
    while (bus.avg_valid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_errors++;
      $display("FAIL %s_valid_timeout: got %0d cycles expected < %0d", tag, k, budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus.fifo_push = 1'b1;
    push_data = 8'hAA;
    repeat (3) tick();
    bus.fifo_push = 1'b0;
    reset = 1'b1;
    n_checks++;
    if (bus.fifo_pop !== 1'b0 || bus.avg_valid !== 1'b0 || bus.avg_data !== '0 ||
        bus.window_full !== 1'b0 || dbg_state !== E_IDLE) begin
      n_errors++;
      $display("FAIL reset_outputs: got pop=%b valid=%b data=%0d wf=%b st=%0d expected 0 0 0 0 0",
               bus.fifo_pop, bus.avg_valid, bus.avg_data, bus.window_full, dbg_state);
    end
    tick();
    n_checks++;
    if (dbg_occ !== '0 || bus.fifo_pop !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_occ: got occ=%0d pop=%b expected 0 0", dbg_occ, bus.fifo_pop);
    end
  endtask

  task automatic test_fill();
    int o0;
    o0 = n_out;
    push_sample(8'd4);
    push_sample(8'd8);
    push_sample(8'd12);
    push_sample(8'd16);
    wait_idle(100, "fill");
    n_checks++;
    if (n_out - o0 != 1 || last_avg !== 8'd10 || bus.window_full !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_first: got outs=%0d avg=%0d wf=%b expected 1 10 1", n_out - o0, last_avg,
               bus.window_full);
    end
    push_sample(8'd20);
    wait_idle(100, "fill20");
    n_checks++;
    if (n_out - o0 != 2 || last_avg !== 8'd14) begin
      n_errors++;
      $display("FAIL fill_20: got outs=%0d avg=%0d expected 2 14", n_out - o0, last_avg);
    end
  endtask

  task automatic test_spacing();
    int p0;
    p0 = n_pops;
    for (int i = 0; i < 6; i++) push_sample(DW'($urandom_range(0, 255)));
    wait_idle(200, "spacing");
    n_checks++;
    if (n_pops - p0 != 6 || dbg_occ !== '0) begin
      n_errors++;
      $display("FAIL spacing_pops: got pops=%0d occ=%0d expected 6 0", n_pops - p0, dbg_occ);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    logic [DW-1:0] held;
    p0 = n_pops;
    bus.avg_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_sample(DW'($urandom_range(0, 255)));
    wait_valid(50, "bp");
    held = (exp_q.size() != 0) ? exp_q[0] : 'x;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.avg_valid !== 1'b1 || bus.avg_data !== held || n_pops - p0 != 1 || dbg_occ !== CW'(2)) begin
        n_errors++;
        $display("FAIL bp_hold: got valid=%b data=%0d pops=%0d occ=%0d expected 1 %0d 1 2",
                 bus.avg_valid, bus.avg_data, n_pops - p0, dbg_occ, held);
      end
      tick();
    end
    bus.avg_ready = 1'b1;
    wait_idle(100, "bp_drain");
    n_checks++;
    if (n_pops - p0 != 3) begin
      n_errors++;
      $display("FAIL bp_resume: got pops=%0d expected 3", n_pops - p0);
    end
  endtask

  task automatic test_rounding();
    logic [DW-1:0] want;
`ifdef PROMEDIO_REDONDEO_EN
    want = 8'd2;
`else
    want = 8'd1;
`endif
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_clear();
    n_checks++;
    if (bus.window_full !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_idle_wf: got %b expected 0", bus.window_full);
    end
    push_sample(8'd1);
    push_sample(8'd2);
    push_sample(8'd2);
    push_sample(8'd2);
    wait_idle(100, "round");
    n_checks++;
    if (last_avg !== want) begin
      n_errors++;
      $display("FAIL round_1222: got %0d expected %0d", last_avg, want);
    end
    for (int i = 0; i < 4; i++) push_sample(8'd255);
    wait_idle(100, "round255");
    n_checks++;
    if (last_avg !== 8'd255) begin
      n_errors++;
      $display("FAIL round_255: got %0d expected 255", last_avg);
    end
  endtask

  task automatic test_clear_nocfg();
    int o0, p0, k;
    bus.avg_ready = 1'b0;
    push_sample(DW'($urandom_range(0, 255)));
    wait_valid(50, "clr");
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_clear();
    n_checks++;
    if (bus.avg_valid !== 1'b0 || bus.window_full !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_out: got valid=%b wf=%b expected 0 0", bus.avg_valid, bus.window_full);
    end
    bus.avg_ready = 1'b1;
    o0 = n_out;
    for (int i = 0; i < 3; i++) push_sample(DW'($urandom_range(0, 255)));
    wait_idle(100, "clr3");
    n_checks++;
    if (n_out != o0) begin
      n_errors++;
      $display("FAIL clear_refill: got %0d outputs expected 0", n_out - o0);
    end
    p0 = n_pops;
    bus.fifo_nocfg = 1'b1;
    for (int i = 0; i < 3; i++) push_sample(DW'($urandom_range(0, 255)));
    repeat (10) tick();
    n_checks++;
    if (n_pops != p0 || dbg_occ !== CW'(3)) begin
      n_errors++;
      $display("FAIL nocfg_hold: got pops=%0d occ=%0d expected 0 3", n_pops - p0, dbg_occ);
    end
    bus.fifo_nocfg = 1'b0;
    k = 0;
    while (bus.fifo_pop !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    push_sample(DW'($urandom_range(0, 255)));
    n_checks++;
    if (k >= 20 || dbg_occ !== CW'(3)) begin
      n_errors++;
      $display("FAIL push_pop_same: got occ=%0d wait=%0d expected occ 3", dbg_occ, k);
    end
    wait_idle(100, "nocfg_drain");
    n_checks++;
    if (n_pops - p0 != 4 || n_out - o0 != 4) begin
      n_errors++;
      $display("FAIL nocfg_drain: got pops=%0d outs=%0d expected 4 4", n_pops - p0, n_out - o0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.fifo_push  = (fifo_q.size() < 40) && ($urandom_range(0, 99) < 45);
      push_data      = DW'($urandom);
      bus.fifo_full  = ($urandom_range(0, 9) == 0);
      bus.avg_ready  = ($urandom_range(0, 3) != 0);
      bus.fifo_nocfg = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.fifo_push  = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.avg_ready  = 1'b1;
    bus.fifo_nocfg = 1'b0;
    wait_idle(400, "random");
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL random_pending: got %0d outputs missing expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int o0;
    for (int i = 0; i < 5; i++) push_sample(DW'($urandom_range(0, 255)));
    repeat (2) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if (bus.avg_valid !== 1'b0 || bus.fifo_pop !== 1'b0 || bus.window_full !== 1'b0 ||
        dbg_occ !== '0 || dbg_state !== E_IDLE) begin
      n_errors++;
      $display("FAIL reset_mid: got valid=%b pop=%b wf=%b occ=%0d st=%0d expected all 0",
               bus.avg_valid, bus.fifo_pop, bus.window_full, dbg_occ, dbg_state);
    end
    o0 = n_out;
    for (int i = 0; i < 4; i++) push_sample(DW'($urandom_range(0, 255)));
    wait_idle(100, "reset_mid");
    n_checks++;
    if (n_out - o0 != 1) begin
      n_errors++;
      $display("FAIL reset_mid_refill: got %0d outputs expected 1", n_out - o0);
    end
  endtask

  initial begin
    bus.fifo_push  = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.fifo_nocfg = 1'b0;
    bus.fifo_data  = '0;
    bus.clear      = 1'b0;
    bus.avg_ready  = 1'b1;
    push_data      = '0;
    test_reset();
    test_fill();
    test_spacing();
    test_backpressure();
    test_rounding();
    test_clear_nocfg();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
